// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Instruction issue controller sitting in front of a processor core's
// instruction input. A small program store is filled word-by-word through a
// load port while the sequencer is not busy. On start it walks the store from
// PC 0 and fetches one word per FETCH cycle. It presents each non-zero word to
// the core with a valid/ready handshake. It stops on the HALT word (all zeros)
// or flags an error if the PC would run past the last word.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (program store is not cleared)
//   load_en      write load_data to load_addr (ignored while busy)
//   load_addr    program store write address
//   load_data    program word
//   start        begin execution at PC 0 (ignored while busy)
//   abort        return to IDLE next cycle; highest priority
//   instr_out    instruction presented to the core
//   instr_valid  instr_out is valid
//   instr_ready  core accepts instr_out this cycle
//   pc_out       address of the current/last fetched word
//   busy         state is FETCH or ISSUE
//   done         HALT reached; held until next start (cleared by abort)
//   err          PC overran DEPTH-1; held until next start (cleared by abort)
//   issue_cnt    instructions accepted since last start (saturating)
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic          abort,
    output logic [31:0]   instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   issue_cnt
);

    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_mem [DEPTH];

    logic [31:0]   r_instr;
    logic          r_valid;
    logic [AW-1:0] r_pc;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [AW:0]   r_cnt;

    logic [31:0]   w_instr_nxt;
    logic          w_valid_nxt;
    logic [AW-1:0] w_pc_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_err_nxt;
    logic [AW:0]   w_cnt_nxt;

    logic [31:0]   w_fetch_word;
    logic          w_last_pc;
    logic          w_accept;
    logic          w_load_ok;

    assign w_fetch_word = r_mem[r_pc];
    assign w_last_pc    = (r_pc == LAST_PC);
    // An accept coinciding with abort is dropped and not counted.
    assign w_accept     = (r_state == S_ISSUE) && r_valid && instr_ready && !abort;
    assign w_load_ok    = load_en && !r_busy;

    // ------------------------------------------------------------------
    // Program store: no reset, so a program survives rst_n. Because the
    // write lands on the same edge that moves IDLE->FETCH, the FETCH read
    // of the following cycle already sees a word loaded alongside start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = (w_fetch_word == '0) ? S_HALTED : S_ISSUE;
            end
            S_ISSUE: begin
                if (r_valid && instr_ready) begin
                    w_state_nxt = w_last_pc ? S_ERROR : S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. Every output is registered so the
    // core sees glitch-free signals that change only on clock edges.
    // ------------------------------------------------------------------
    always_comb begin
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_pc_nxt    = r_pc;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        if (abort) begin
            // pc_out and issue_cnt keep their last values for inspection.
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (start) begin
                        w_pc_nxt   = '0;
                        w_done_nxt = 1'b0;
                        w_err_nxt  = 1'b0;
                        w_cnt_nxt  = '0;
                    end
                end
                S_FETCH: begin
                    w_instr_nxt = w_fetch_word;
                    if (w_fetch_word == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        w_valid_nxt = 1'b0;
                        if (r_cnt != '1) begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                        // The PC never wraps; the last slot must hold HALT.
                        if (w_last_pc) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_pc_nxt = r_pc + 1'b1;
                        end
                    end
                end
                default: begin
                    w_valid_nxt = 1'b0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_ISSUE);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= '0;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_pc    <= w_pc_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign pc_out      = r_pc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign issue_cnt   = r_cnt;

endmodule
